// File: rtl/rr_extend_arbiter_if.sv
// Request/grant bundle between N requesters and the shared-resource arbiter.
// master = requester side (drives req), slave = arbiter side (drives status).
interface rr_extend_arbiter_if #(
  parameter int N   = 4,
  parameter int IDW = (N > 1) ? $clog2(N) : 1
);
  logic [N-1:0]   req;
  logic [N-1:0]   gnt;
  logic [IDW-1:0] gnt_id;
  logic           busy;
  logic           done;

  modport master (output req, input gnt, gnt_id, busy, done);
  modport slave  (input req, output gnt, gnt_id, busy, done);
endinterface

// File: rtl/rr_extend_arbiter.sv
// Round-robin arbiter for a single resource with a fixed occupancy window.
// Timing: request sampled at an edge -> one GRANT cycle -> HOLD EXTEND cycles,
// with done in the last EXTEND cycle. Requests are sampled only when idle or
// in the final EXTEND cycle, so back-to-back ownership has no idle bubble.
module rr_extend_arbiter #(
  parameter int N    = 4,
  parameter int HOLD = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  rr_extend_arbiter_if.slave bus
);
  localparam int IDW = $clog2(N);
  // Counter only needs to hold HOLD-1; keep at least one bit for HOLD=1.
  localparam int CW  = (HOLD > 1) ? $clog2(HOLD) : 1;

  typedef enum logic [1:0] {IDLE, GRANT, EXTEND} state_e;

  state_e         state_q, state_d;
  logic [IDW-1:0] id_q, id_d;
  logic [IDW-1:0] last_q, last_d;
  logic [CW-1:0]  ext_cnt_q, ext_cnt_d;

  logic [IDW-1:0] pick;
  logic           any_req;

  // Rotating priority search: start just after the previous owner and wrap.
  // Scanning offsets from far to near lets the nearest set bit win.
  always_comb begin
    int idx;
    idx     = 0;
    pick    = '0;
    any_req = |bus.req;
    for (int i = N; i >= 1; i--) begin
      idx = (int'(last_q) + i) % N;
      if (bus.req[idx]) pick = IDW'(idx);
    end
  end

  // Next-state logic: IDLE / GRANT / EXTEND sequencing and window countdown.
  always_comb begin
    state_d   = state_q;
    id_d      = id_q;
    last_d    = last_q;
    ext_cnt_d = ext_cnt_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d = GRANT;
          id_d    = pick;
        end
      end
      GRANT: begin
        // Priority pointer moves only once a grant has actually been issued.
        last_d    = id_q;
        state_d   = EXTEND;
        ext_cnt_d = CW'(HOLD - 1);
      end
      EXTEND: begin
        if (ext_cnt_q == '0) begin
          if (any_req) begin
            state_d = GRANT;
            id_d    = pick;
          end else begin
            state_d = IDLE;
          end
        end else begin
          ext_cnt_d = ext_cnt_q - CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; last resets to N-1 so requester 0 leads after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      id_q      <= '0;
      last_q    <= IDW'(N - 1);
      ext_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      id_q      <= id_d;
      last_q    <= last_d;
      ext_cnt_q <= ext_cnt_d;
    end
  end

  // Outputs decode from registered state only, so async reset clears them at once.
  always_comb begin
    bus.gnt    = '0;
    bus.gnt_id = id_q;
    bus.busy   = (state_q != IDLE);
    bus.done   = (state_q == EXTEND) && (ext_cnt_q == '0);
    if (state_q == GRANT) bus.gnt[id_q] = 1'b1;
  end
endmodule

// File: tb/tb_rr_extend_arbiter.sv
// Scoreboard bench: the stimulus process steps a cycle-level reference model
// that pushes expected grants/dones into queues; a negedge monitor pops and
// compares whenever the DUT shows gnt or done, and checks busy every cycle.
module tb_rr_extend_arbiter;
  localparam int N    = 4;
  localparam int HOLD = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #20 clk = ~clk;

  rr_extend_arbiter_if #(.N(N)) bus ();

  rr_extend_arbiter #(.N(N), .HOLD(HOLD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int cyc;
    int id;
  } gexp_t;

  gexp_t gq[$];
  int    dq[$];

  int checks   = 0;
  int failures = 0;

  // Reference model state: cycle number, previous owner, owned window.
  int mcyc     = 0;
  int m_last   = N - 1;
  int m_bstart = -10;
  int m_bend   = -10;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, mcyc);
    end
  endtask

  function automatic int rr_pick(input int last, input logic [N-1:0] r);
    for (int off = 1; off <= N; off++) begin
      if (r[(last + off) % N]) return (last + off) % N;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_last   = N - 1;
    m_bstart = -10;
    m_bend   = -10;
    gq.delete();
    dq.delete();
  endtask

  // Called right after each posedge: decides what the edge that just
  // happened should have done, in terms of ownership windows.
  task automatic model_step();
    int prev;
    int w;
    prev = mcyc;
    mcyc = mcyc + 1;
    if (!rst_n) begin
      model_reset();
    end else if (prev >= m_bend && bus.req != '0) begin
      w = rr_pick(m_last, bus.req);
      gq.push_back('{mcyc, w});
      dq.push_back(mcyc + HOLD);
      m_bstart = mcyc;
      m_bend   = mcyc + HOLD;
      m_last   = w;
    end
  endtask

  task automatic tick(input logic [N-1:0] v);
    @(negedge clk);
    bus.req = v;
    @(posedge clk);
    model_step();
  endtask

  // Monitor: compare DUT outputs against the model away from the posedge.
  always @(negedge clk) begin
    gexp_t e;
    int    d;
    int    eb;
    #1;
    eb = (mcyc >= m_bstart && mcyc <= m_bend) ? 1 : 0;
    chk("busy", int'(bus.busy), eb);
    chk("gnt_onehot0", int'($onehot0(bus.gnt)), 1);
    if (bus.gnt != '0) chk("gnt_implies_busy", int'(bus.busy), 1);
    if (bus.done) chk("done_busy_no_gnt", int'(bus.busy && bus.gnt == '0), 1);
    while (gq.size() > 0 && gq[0].cyc < mcyc) begin
      e = gq.pop_front();
      chk("gnt_missing", -1, e.cyc);
    end
    while (dq.size() > 0 && dq[0] < mcyc) begin
      d = dq.pop_front();
      chk("done_missing", -1, d);
    end
    if (bus.gnt != '0) begin
      if (gq.size() == 0) chk("gnt_unexpected", int'(bus.gnt), 0);
      else begin
        e = gq.pop_front();
        chk("gnt_cycle", mcyc, e.cyc);
        chk("gnt_vec", int'(bus.gnt), 1 << e.id);
        chk("gnt_id", int'(bus.gnt_id), e.id);
      end
    end
    if (bus.done) begin
      if (dq.size() == 0) chk("done_unexpected", 1, 0);
      else begin
        d = dq.pop_front();
        chk("done_cycle", mcyc, d);
      end
    end
  end

  initial begin
    logic [N-1:0] v;
    bus.req = '0;
    // Reset held for two edges, then quiet for five cycles.
    repeat (2) begin
      @(posedge clk);
      model_step();
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    model_step();
    repeat (5) tick('0);

    // Single one-cycle request.
    tick(4'b0100);
    repeat (5) tick('0);

    // All requesting: rotation 0,1,2,3,0...
    repeat (15) tick(4'b1111);
    repeat (4) tick('0);

    // Wrap between 0 and 3.
    repeat (15) tick(4'b1001);
    repeat (4) tick('0);

    // Pulse on req[2] in the non-final EXTEND cycle: ignored.
    tick(4'b0001);
    tick('0);
    tick(4'b0100);
    tick('0);
    repeat (3) tick('0);
    // Same pulse in the final EXTEND cycle: back-to-back grant to 2.
    tick(4'b0001);
    tick('0);
    tick('0);
    tick(4'b0100);
    repeat (5) tick('0);

    // Randomized traffic.
    for (int i = 0; i < 300; i++) begin
      v = N'($urandom_range(0, (1 << N) - 1));
      if ($urandom_range(0, 3) == 0) v = '0;
      tick(v);
    end
    repeat (5) tick('0);

    // Async reset while in a non-final EXTEND cycle.
    tick(4'b0001);
    tick('0);
    #5;
    rst_n = 1'b0;
    model_reset();
    #5;
    chk("async_rst_busy", int'(bus.busy), 0);
    chk("async_rst_gnt", int'(bus.gnt), 0);
    chk("async_rst_done", int'(bus.done), 0);
    @(negedge clk);
    bus.req = 4'b0110;
    @(posedge clk);
    model_step();
    @(negedge clk);
    rst_n = 1'b1;
    bus.req = 4'b0110;
    @(posedge clk);
    model_step();
    if (gq.size() > 0) chk("post_rst_first_id", gq[0].id, 1);
    else chk("post_rst_first_id", -1, 1);
    repeat (4) tick(4'b0110);
    repeat (6) tick('0);

    @(negedge clk);
    #2;
    chk("gnt_queue_drained", gq.size(), 0);
    chk("done_queue_drained", dq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
